// File: rtl/serial_add_eight_pkg.sv
// Shared types and constants for the bit-serial adder.
// State enum is also exported on the top's debug port.
package serial_add_eight_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_eight_if.sv
// Sequencer <-> serial adder bundle.
// start is sampled only while the adder is idle; done pulses one cycle when the result is valid.
interface serial_add_eight_if #(
  parameter int WIDTH = serial_add_eight_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             cIn;
  logic             enable;
  logic             busy;
  logic             done;
  logic             cOut;
  logic             ovf;
  logic [WIDTH-1:0] dOut;

  modport master (
    output start, d0, d1, cIn, enable,
    input  busy, done, cOut, ovf, dOut
  );

  modport slave (
    input  start, d0, d1, cIn, enable,
    output busy, done, cOut, ovf, dOut
  );

endinterface

// File: rtl/serial_add_eight_full_adder_cell.sv
// Single full-adder bit slice, reused by the serial adder on every RUN cycle.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic sum,
  output logic cOut
);

  assign sum  = a ^ b ^ cIn;
  assign cOut = (a & b) | (a & cIn) | (b & cIn);

endmodule

// File: rtl/serial_add_eight.sv
// Bit-serial ripple adder: d0 + d1 + cIn, one bit per clock, LSB first.
// Result, carry-out and overflow hold until the next accepted start's first RUN cycle.
module serial_add_eight
  import serial_add_eight_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_add_eight_if.slave      bus,
  output state_t                 dbgState
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    count;
  logic             cOutR;
  logic             ovfR;
  logic             busyR;
  logic             doneR;
  logic             faSum;
  logic             faCarry;

  full_adder_cell u_cell (
    .a    (opA[0]),
    .b    (opB[0]),
    .cIn  (carry),
    .sum  (faSum),
    .cOut (faCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opA    <= '0;
      opB    <= '0;
      result <= '0;
      carry  <= 1'b0;
      count  <= '0;
      cOutR  <= 1'b0;
      ovfR   <= 1'b0;
      busyR  <= 1'b0;
      doneR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opA   <= bus.d0;
            opB   <= bus.d1;
            carry <= bus.cIn;
            count <= '0;
            busyR <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {faSum, result[WIDTH-1:1]};
          opA    <= opA >> 1;
          opB    <= opB >> 1;
          carry  <= faCarry;
          count  <= count + 1'b1;
          if (count == LAST) begin
            // carry here is the carry into the MSB, faCarry the carry out of it
            cOutR <= faCarry;
            ovfR  <= carry ^ faCarry;
            busyR <= 1'b0;
            doneR <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          doneR <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busyR <= 1'b0;
          doneR <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busyR;
  assign bus.done = doneR;
  assign bus.cOut = cOutR;
  assign bus.ovf  = ovfR;
  assign bus.dOut = result & {WIDTH{bus.enable}};
  assign dbgState = state;

endmodule

// File: tb/tb_serial_add_eight.sv
// Self-checking bench for serial_add_eight: directed cases plus randomized operands
// against an arithmetic reference model ({cOut,sum} = d0 + d1 + cIn).
module tb_serial_add_eight;
  import serial_add_eight_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst_n;
  state_t dbgState;
  int     total;
  int     bad;

  logic [W+1:0] exp_q[$];

  serial_add_eight_if #(.WIDTH(W)) bus ();

  serial_add_eight #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: returns {ovf, cOut, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    logic [W:0]   full;
    logic         o;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    o    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {o, full};
  endfunction

  // driver: issue one start and observe 20 cycles after the start edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat, output int busyCnt, output int doneCnt);
    @(negedge clk);
    bus.d0    = a;
    bus.d1    = b;
    bus.cIn   = ci;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1; busyCnt = 0; doneCnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneCnt++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 2) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.d0 = '0; bus.d1 = '0; bus.cIn = 1'b0; bus.enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cOut, bus.ovf, bus.dOut} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b cOut=%b ovf=%b dOut=%h want all 0",
               bus.busy, bus.done, bus.cOut, bus.ovf, bus.dOut);
    end
    total++;
    if (dbgState !== IDLE) begin
      bad++; $display("FAIL reset_state got %0d want %0d", dbgState, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int lat, bc, dc;
    run_op(8'h3C, 8'h05, 1'b0, lat, bc, dc);
    total++;
    if (lat != W) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    total++;
    if (bc != W) begin bad++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, W); end
    total++;
    if (dc != 1) begin bad++; $display("FAIL basic_done_count got %0d want 1", dc); end
    total++;
    if ({bus.dOut, bus.cOut, bus.ovf} !== {8'h41, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got dOut=%h cOut=%b ovf=%b want 41 0 0",
               bus.dOut, bus.cOut, bus.ovf);
    end
  endtask

  task automatic test_directed_case(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic [W-1:0] es,
                                    input logic ec, input logic eo);
    int lat, bc, dc;
    run_op(a, b, ci, lat, bc, dc);
    total++;
    if (dc != 1 || {bus.dOut, bus.cOut, bus.ovf} !== {es, ec, eo}) begin
      bad++;
      $display("FAIL directed %h+%h+%b got dOut=%h cOut=%b ovf=%b done=%0d want %h %b %b 1",
               a, b, ci, bus.dOut, bus.cOut, bus.ovf, dc, es, ec, eo);
    end
  endtask

  task automatic test_enable();
    int dc;
    test_directed_case(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    @(negedge clk);
    bus.enable = 1'b0;
    #1;
    total++;
    if (bus.dOut !== 8'h00 || bus.cOut !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL enable_low got dOut=%h cOut=%b ovf=%b want 00 0 0",
               bus.dOut, bus.cOut, bus.ovf);
    end
    dc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dc++;
    end
    bus.enable = 1'b1;
    #1;
    total++;
    if (bus.dOut !== 8'h41 || dc != 0) begin
      bad++; $display("FAIL enable_high got dOut=%h dones=%0d want 41 0", bus.dOut, dc);
    end
  endtask

  task automatic test_ignore_start();
    int dc;
    @(negedge clk);
    bus.d0 = 8'h3C; bus.d1 = 8'h05; bus.cIn = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (k >= 2 && k < 7) begin
        bus.start = 1'b1;
        bus.d0 = W'($urandom);
        bus.d1 = W'($urandom);
        bus.cIn = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) dc++;
      @(posedge clk);
      #1;
    end
    total++;
    if (dc != 1 || bus.dOut !== 8'h41) begin
      bad++; $display("FAIL ignore_start got dones=%0d dOut=%h want 1 41", dc, bus.dOut);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc, dc;
    @(negedge clk);
    bus.d0 = 8'hFF; bus.d1 = 8'hFF; bus.cIn = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cOut, bus.ovf, bus.dOut} !== '0 || dbgState !== IDLE) begin
      bad++;
      $display("FAIL mid_run_reset got busy=%b done=%b cOut=%b ovf=%b dOut=%h state=%0d want 0",
               bus.busy, bus.done, bus.cOut, bus.ovf, bus.dOut, dbgState);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, lat, bc, dc);
    total++;
    if (lat != W || bus.dOut !== 8'h30) begin
      bad++; $display("FAIL after_reset_op got lat=%0d dOut=%h want %0d 30", lat, bus.dOut, W);
    end
  endtask

  task automatic test_random(input int n);
    int           lat, bc, dc;
    logic [W-1:0] a, b;
    logic         ci, en;
    logic [W+1:0] exp;
    for (int i = 0; i < n; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom_range(1, 0));
      en = ($urandom_range(9, 0) != 0);
      exp_q.push_back(model(a, b, ci));
      @(negedge clk);
      bus.enable = en;
      run_op(a, b, ci, lat, bc, dc);
      exp = exp_q.pop_front();
      total++;
      if (lat != W || dc != 1 || bus.cOut !== exp[W] || bus.ovf !== exp[W+1]
          || bus.dOut !== (exp[W-1:0] & {W{en}})) begin
        bad++;
        $display("FAIL random %h+%h+%b en=%b got dOut=%h cOut=%b ovf=%b lat=%0d want %h %b %b %0d",
                 a, b, ci, en, bus.dOut, bus.cOut, bus.ovf, lat,
                 exp[W-1:0] & {W{en}}, exp[W], exp[W+1], W);
      end
    end
    bus.enable = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_directed_case(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_directed_case(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    test_directed_case(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    test_directed_case(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_enable();
    test_ignore_start();
    test_async_reset();
    test_random(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
